// File: rtl/spi_master.sv
// Mode-0 SPI master: one WIDTH-bit frame per start, MSB first.
// sck half-period is CLKDIV clk cycles; rx word lands on rxData at frame end.
module spi_master #(
  parameter int CLKDIV = 4,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  input  logic             sdi,
  output logic             sck,
  output logic             sdo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData
);

  localparam int EW = $clog2(2 * WIDTH + 1);

  localparam logic [7:0]    DIV_LAST  = 8'(CLKDIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WIDTH - 1);
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       div_cnt;
  logic [EW-1:0]    edge_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;

  logic tick;
  logic final_fall;

  // A toggle is due when the divider has spanned a full half-period.
  always_comb begin
    tick       = (state == SHIFT) && (div_cnt == DIV_LAST);
    final_fall = tick && sck && (edge_cnt == EDGE_LAST);
  end

  // Frame sequencer: owns every register and output of the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sck      <= 1'b0;
      sdo      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rxData   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          sck  <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state    <= SHIFT;
            tx_sr    <= txData;
            sdo      <= txData[WIDTH-1];
            div_cnt  <= '0;
            edge_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        SHIFT: begin
          if (!tick) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + EDGE_ONE;
            if (!sck) begin
              sck   <= 1'b1;
              rx_sr <= {rx_sr[WIDTH-2:0], sdi};
            end else if (final_fall) begin
              sck    <= 1'b0;
              sdo    <= 1'b0;
              rxData <= rx_sr;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              sck   <= 1'b0;
              tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
              sdo   <= tx_sr[WIDTH-2];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          sck   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed and random frames on two instances
// (CLKDIV=4 and CLKDIV=2), checked against a bit-level slave/loopback model.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [31:0] txData;
  logic        sdi1, sdi2;
  logic        sck1, sck2, sdo1, sdo2;
  logic        busy1, busy2, done1, done2;
  logic [31:0] rx1, rx2;

  always #5 clk = ~clk;

  spi_master #(.CLKDIV(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start1), .txData(txData),
    .sdi(sdi1), .sck(sck1), .sdo(sdo1), .busy(busy1),
    .done(done1), .rxData(rx1)
  );

  spi_master #(.CLKDIV(2), .WIDTH(32)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .txData(txData),
    .sdi(sdi2), .sck(sck2), .sdo(sdo2), .busy(busy2),
    .done(done2), .rxData(rx2)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;

  bit          sel = 1'b0;
  bit          lb = 1'b1;
  logic [31:0] slv = '0;
  logic [31:0] exp_tx = '0;
  logic [31:0] lrx [2];
  int          rises = 0;
  int          falls = 0;
  int          sdo_bad = 0;
  int          rbase = 0;
  int          fbase = 0;
  int          fidx;
  logic        slv_bit;

  logic        sck_m, sdo_m, busy_m, done_m;
  logic [31:0] rx_m;

  assign sck_m  = sel ? sck2 : sck1;
  assign sdo_m  = sel ? sdo2 : sdo1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign rx_m   = sel ? rx2 : rx1;

  always @(posedge clk) cyc <= cyc + 1;

  // Remote slave: presents its word MSB first, advancing on sck falls.
  always_comb begin
    fidx    = falls - fbase;
    slv_bit = 1'b0;
    if (fidx >= 0 && fidx < 32) slv_bit = slv[31-fidx];
  end

  assign sdi1 = lb ? sdo1 : slv_bit;
  assign sdi2 = lb ? sdo2 : slv_bit;

  always @(negedge sck_m) falls <= falls + 1;

  // At every sck rise the master must be presenting the next tx bit.
  always @(posedge sck_m) begin
    if (sdo_m !== exp_tx[31-((rises-rbase)&31)]) sdo_bad <= sdo_bad + 1;
    rises <= rises + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input bit s, input logic [31:0] tx,
                       input bit loop, input logic [31:0] sw,
                       input bit glitch);
    int k;
    int div;
    int b0;
    logic [31:0] exp_rx;
    div    = s ? 2 : 4;
    exp_rx = loop ? tx : sw;
    @(negedge clk);
    sel = s; lb = loop; slv = sw; exp_tx = tx; txData = tx;
    rbase = rises; fbase = falls; b0 = sdo_bad;
    if (s) start2 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    chk("busy_at_T", busy_m, 1);
    chk("sdo_at_T", sdo_m, tx[31]);
    k = 0;
    while (busy_m === 1'b1 && k < 3000) begin
      @(posedge clk); #1;
      k++;
      if (glitch && k == 1) txData = '0;
      if (glitch && k == 49) begin
        if (s) start2 = 1'b1;
        else start1 = 1'b1;
      end
      if (glitch && k == 50) begin
        start1 = 1'b0; start2 = 1'b0;
      end
      if (k == 20) chk("rx_hold", rx_m, lrx[s]);
    end
    chk("busy_cycles", k, 64 * div);
    chk("done_pulse", done_m, 1);
    chk("sck_low_end", sck_m, 0);
    chk("sdo_low_end", sdo_m, 0);
    chk("rxData", rx_m, exp_rx);
    chk("sck_rises", rises - rbase, 32);
    chk("sdo_stable", sdo_bad - b0, 0);
    lrx[s] = exp_rx;
    @(posedge clk); #1;
    chk("done_cleared", done_m, 0);
    @(posedge clk); #1;
    chk("no_queued", busy_m, 0);
  endtask

  int          st [3];
  int          sr [3];
  int          nst;
  int          k;
  bit          pb;
  logic [31:0] tx;

  initial begin
    lrx[0] = '0;
    lrx[1] = '0;
    reset  = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    txData = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck1, 0);
    chk("rst_sdo", sdo1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rx", rx1, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    frame(0, 32'hA5C3_0F81, 1, '0, 0);
    frame(0, 32'hFFFF_FFFF, 0, 32'h0000_03FF, 0);
    frame(0, 32'h1234_5678, 1, '0, 1);

    for (int i = 0; i < 3; i++) frame(0, $urandom, 1, '0, 0);
    for (int i = 0; i < 2; i++) frame(0, $urandom, 0, $urandom, 0);

    // start held high: frames every 2*WIDTH*CLKDIV+2 cycles
    @(negedge clk);
    tx = $urandom;
    sel = 0; lb = 1; txData = tx; exp_tx = tx;
    rbase = rises; fbase = falls;
    start1 = 1'b1;
    nst = 0;
    pb = 1'b0;
    for (int c = 0; c < 2000 && nst < 3; c++) begin
      @(posedge clk); #1;
      if (busy1 && !pb) begin
        st[nst] = cyc;
        sr[nst] = rises;
        nst++;
      end
      pb = busy1;
    end
    start1 = 1'b0;
    chk("hold_starts", nst, 3);
    chk("hold_gap1", st[1] - st[0], 258);
    chk("hold_gap2", st[2] - st[1], 258);
    chk("hold_pulses1", sr[1] - sr[0], 32);
    chk("hold_pulses2", sr[2] - sr[1], 32);
    k = 0;
    while (busy1 === 1'b1 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_done", done1, 1);
    chk("hold_pulses3", rises - sr[2], 32);
    chk("hold_rx", rx1, tx);
    lrx[0] = tx;
    repeat (2) @(negedge clk);

    // reset in the middle of a frame, while sck is high
    @(negedge clk);
    tx = $urandom;
    sel = 0; lb = 1; txData = tx; exp_tx = tx;
    rbase = rises; fbase = falls;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("abort_sck_hi", sck1, 1);
    reset = 1'b1;
    #1;
    chk("abort_sck", sck1, 0);
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_rx", rx1, 0);
    chk("abort_sdo", sdo1, 0);
    lrx[0] = '0;
    lrx[1] = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done1, 0);
    frame(0, $urandom, 1, '0, 0);

    // CLKDIV=2 instance
    frame(1, 32'h8000_0001, 1, '0, 0);
    frame(1, $urandom, 1, '0, 0);
    frame(1, $urandom, 0, $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLKDIV, default 4, sck half-period in clk cycles; legal range 2..255.
REQ-002 Parameter: WIDTH, default 32, frame length in bits.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled only while busy=0.
REQ-006 txData  input  WIDTH  word to transmit, MSB first.
REQ-007 sdi  input  1  serial data from the remote SPI slave.
REQ-008 sck  output  1  serial clock, registered, idle low.
REQ-009 sdo  output  1  serial data to the remote slave, registered.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.
REQ-012 rxData  output  WIDTH  word received on sdi, MSB first.

Function
REQ-013 Mode 0 only: sdo changes while sck is low or on sck falling edges; sdi is captured on sck rising edges.
REQ-014 States: IDLE, SHIFT, DONE; reset enters IDLE.
REQ-015 IDLE: sck=0, busy=0; start=1 at clk edge T moves to SHIFT, loads txData into the tx shift register, and clears the divider and edge counters.
REQ-016 txData is sampled only at edge T; later changes do not affect the frame in progress.
REQ-017 sdo = txData[WIDTH-1] from edge T.
REQ-018 In SHIFT, sck toggles at edges T+n*CLKDIV, n=1..2*WIDTH; odd n rise, even n fall.
REQ-019 At each rising edge n, the value of sdi present just before that clk edge shifts into the LSB of the rx shift register.
REQ-020 At each falling edge n<2*WIDTH, sdo advances to the next lower tx bit; bit WIDTH-1-k is driven from edge T+2k*CLKDIV until edge T+(2k+2)*CLKDIV.
REQ-021 At edge T+2*WIDTH*CLKDIV (final falling edge): sck=0, sdo=0, the rx shift register copies to rxData, busy=0, done=1, state moves to DONE.
REQ-022 DONE lasts exactly one cycle, then returns to IDLE with done=0; start is ignored in DONE.
REQ-023 busy=1 from edge T through the cycle before edge T+2*WIDTH*CLKDIV, i.e. exactly 2*WIDTH*CLKDIV cycles.
REQ-024 Exactly WIDTH rising and WIDTH falling sck edges occur per frame, with no glitches or partial pulses.
REQ-025 start while busy=1 is ignored and never queued.
REQ-026 The earliest next frame accepts start at edge T+2*WIDTH*CLKDIV+2; back-to-back frames put one DONE cycle plus one IDLE cycle between them.
REQ-027 rxData holds its value between frames and changes only at REQ-021.
REQ-028 The divider counter is CLKDIV-1 wide enough (8 bits) and wraps to 0 on each sck toggle; the edge counter counts 0..2*WIDTH with no overflow.

Reset
REQ-029 reset=1 forces immediately, without a clock: state=IDLE, sck=0, sdo=0, busy=0, done=0, rxData=0, and clears all shift registers and counters.
REQ-030 reset mid-frame aborts the frame: no done pulse, rxData=0, sck returns low asynchronously.
REQ-031 After reset deasserts, the first accepted start begins a full new frame.

Verification
REQ-032 CLKDIV=4, WIDTH=32, txData=0xA5C3_0F81, loopback sdo->sdi, start at T -> exactly 32 sck rises, busy for 256 cycles, done pulse at T+256, rxData=0xA5C3_0F81.
REQ-033 sdi driven by a model slave returning 0x0000_03FF, txData=0xFFFF_FFFF -> rxData=0x0000_03FF; sdo stable across every sck rising edge.
REQ-034 start held high continuously -> frames start at T, T+258, T+516, and each frame has exactly 32 sck pulses.
REQ-035 start pulsed at T+50 during a frame, with txData changed to 0 at T+1 -> ignored; frame still transmits the original word; no extra frame.
REQ-036 reset asserted at T+100 (sck high) -> sck, busy, done, and rxData go to 0 immediately; the next start yields a correct full frame.
REQ-037 CLKDIV=2 boundary, loopback txData=0x8000_0001 -> busy 128 cycles, rxData=0x8000_0001.
